// File: rtl/oddr_pattern_gen.sv
// oddr_pattern_gen: registered rise/fall bit-pair source (clock, PRBS7, word, PRBS7 burst) feeding an ODDR wrapper.
module oddr_pattern_gen #(
    parameter int         WORD_W    = 16,
    parameter logic [6:0] PRBS_SEED = 7'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [WORD_W-1:0] pattern,
    input  logic [7:0]        burst_len,
    input  logic [7:0]        gap_len,
    output logic              d_rise,
    output logic              d_fall,
    output logic              oe,
    output logic              busy,
    output logic              frame_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam int CW = ($clog2(WORD_W) > 8) ? $clog2(WORD_W) : 8;

    logic [1:0]        state, mode_q;
    logic [WORD_W-1:0] pat_q, sh;
    logic [7:0]        blen_q, glen_q, blen_eff;
    logic [6:0]        lfsr, l1, l2, lfsr_next;
    logic [CW-1:0]     cnt;
    logic              b1, b2, last_word, last_burst, last_gap;

    // Two LFSR steps per cycle: first bit goes out on the rising edge, second on the falling edge
    always_comb begin
        b1         = lfsr[6] ^ lfsr[5];
        l1         = {lfsr[5:0], b1};
        b2         = l1[6] ^ l1[5];
        l2         = {l1[5:0], b2};
        lfsr_next  = (lfsr == 7'd0) ? PRBS_SEED : l2;
        blen_eff   = (blen_q == 8'd0) ? 8'd1 : blen_q;
        last_word  = cnt == CW'(WORD_W / 2 - 1);
        last_burst = cnt == CW'(blen_eff - 8'd1);
        last_gap   = cnt == CW'(glen_q - 8'd1);
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 2'd0;
            pat_q      <= '0;
            sh         <= '0;
            blen_q     <= 8'd0;
            glen_q     <= 8'd0;
            lfsr       <= PRBS_SEED;
            cnt        <= '0;
            d_rise     <= 1'b0;
            d_fall     <= 1'b0;
            oe         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            d_rise     <= 1'b0;
            d_fall     <= 1'b0;
            oe         <= 1'b0;
            frame_done <= 1'b0;
            if (lfsr == 7'd0)
                lfsr <= PRBS_SEED;
            case (state)
                IDLE: if (enable) begin
                    state  <= RUN;
                    mode_q <= mode;
                    pat_q  <= pattern;
                    sh     <= pattern;
                    blen_q <= burst_len;
                    glen_q <= gap_len;
                    lfsr   <= PRBS_SEED;
                    cnt    <= '0;
                end
                RUN: if (!enable) begin
                    state <= IDLE;
                end else begin
                    oe <= 1'b1;
                    if (mode_q == 2'd0) begin
                        d_rise <= 1'b1;
                    end else if (mode_q == 2'd2) begin
                        d_rise     <= sh[WORD_W-1];
                        d_fall     <= sh[WORD_W-2];
                        sh         <= last_word ? pat_q : sh << 2;
                        cnt        <= last_word ? '0 : cnt + 1'b1;
                        frame_done <= last_word;
                    end else begin
                        d_rise <= b1;
                        d_fall <= b2;
                        lfsr   <= lfsr_next;
                        if (mode_q == 2'd3) begin
                            cnt        <= last_burst ? '0 : cnt + 1'b1;
                            frame_done <= last_burst;
                            if (last_burst && glen_q != 8'd0)
                                state <= GAP;
                        end
                    end
                end
                GAP: if (!enable) begin
                    state <= IDLE;
                end else begin
                    cnt   <= last_gap ? '0 : cnt + 1'b1;
                    state <= last_gap ? RUN : GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/oddr_pattern_gen.md
# oddr_pattern_gen

Registered bit-pair source that sits directly upstream of the ODDR output wrapper and drives its rising-edge and falling-edge data inputs plus output-enable. Runs in the 100 MHz clock-wizard domain, started and stopped by the VIO `enable` probe. Produces four selectable test patterns so the DDR output pin can be checked on a scope or logic analyser: forwarded clock, PRBS7, a fixed repeating word, and gated PRBS7 bursts.

## Interface
- `WORD_W`, 16: width of the `pattern` word in mode 2. Must be even and ≥ 2.
- `PRBS_SEED`, 7'h7F: LFSR load value. Must be nonzero.
- `clk`  in  1  100 MHz system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request (VIO probe); level-sensitive.
- `mode`  in  2  0 = clock-forward, 1 = PRBS7, 2 = word, 3 = PRBS7 burst.
- `pattern`  in  WORD_W  word for mode 2, transmitted MSB first.
- `burst_len`  in  8  RUN cycles per burst in mode 3. 0 is treated as 1.
- `gap_len`  in  8  idle cycles between bursts in mode 3. 0 means no gap.
- `d_rise`  out  1  bit for the ODDR rising edge (D1).
- `d_fall`  out  1  bit for the ODDR falling edge (D2).
- `oe`  out  1  output enable for the wrapper's tristate; 1 = drive.
- `busy`  out  1  FSM is not in IDLE.
- `frame_done`  out  1  one-cycle pulse on the last pair of each word (mode 2) or burst (mode 3).

## Operation
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - LFSR = `PRBS_SEED`.
  - Counters 0.
- FSM states:
  - IDLE: outputs 0. Leaves when `enable` = 1.
    - Latches `mode`, `pattern`, `burst_len` and `gap_len` into shadow registers.
    - Loads the LFSR with `PRBS_SEED`.
    - Goes to RUN.
  - RUN: drives pattern pairs with `oe` = 1.
    - Mode 3 only: after `burst_len` pairs, goes to GAP if `gap_len` ≠ 0; otherwise starts a new burst immediately in RUN.
  - GAP: `oe` = 0, `d_rise` = `d_fall` = 0, LFSR holds its state.
    - After `gap_len` cycles, returns to RUN.
- `enable` = 0 in RUN or GAP: next state is IDLE and all outputs are 0 on the next cycle. Nothing is completed; there is no drain.
- Changes to the inputs while `busy` = 1 are ignored. New values take effect only after passing through IDLE.
- Mode 0: every RUN cycle drives `d_rise` = 1, `d_fall` = 0, giving a 100 MHz clock on the pin.
- PRBS7 (modes 1 and 3):
  - Polynomial x^7 + x^6 + 1.
  - One step: b = L[6] ^ L[5]; L <= {L[5:0], b}.
  - Two steps per cycle: first b → `d_rise`, second b → `d_fall`.
  - If L reaches 0 (only possible through an SEU), reload `PRBS_SEED` on the next cycle.
  - The LFSR is not reloaded between bursts.
- Mode 2: a shift register S loads the shadow pattern.
  - Each cycle: `d_rise` = S[W-1], `d_fall` = S[W-2], then S shifts left by 2.
  - After WORD_W/2 pairs, S reloads the shadow pattern and `frame_done` pulses with the last pair.
- Mode 3: `frame_done` pulses with the final pair of each burst.
- `rst` overrides `enable` in the same cycle.

## Timing
- All outputs are registered.
- Latency from `enable` high to the first pair and `oe` = 1 is 2 cycles:
  - edge 1: IDLE → RUN and latch inputs;
  - edge 2: outputs valid.
- Latency from `enable` low to `oe` = 0 is 1 cycle.
- `enable` low for a single cycle causes a full restart: the LFSR reseeds and the pattern restarts from the MSB.
- Mode 2 period is WORD_W/2 cycles. PRBS7 repeats every 127 cycles (254 bits).
- Mode 3 period is `burst_len` + `gap_len` cycles, with `oe` high for exactly `burst_len` of them.
- `frame_done` is coincident with the last data pair and never asserts while `oe` = 0.

## Test plan
- **Reset during activity:** `rst` = 1 mid-run in mode 1 → next cycle: all outputs 0, `busy` = 0. After release, `enable` → the PRBS restarts from the seed.
- **Mode 0:** `enable` rises at cycle 0 → from cycle 2, (`d_rise`, `d_fall`, `oe`) = (1, 0, 1) every cycle. `enable` low → `oe` = 0 the next cycle.
- **Mode 1, seed 7'h7F:**
  - First four pairs are (0,0), (0,0), (0,0), (1,0).
  - The 254-bit stream matches a reference PRBS7 model.
  - The pair stream repeats after 127 cycles.
- **Mode 2, `pattern` = 16'hA5C3:**
  - Pairs are (1,0)(1,0)(0,1)(0,1)(1,1)(0,0)(0,0)(1,1), then repeat.
  - `frame_done` pulses on every 8th pair.
  - Changing `pattern` mid-run has no effect.
- **Mode 3, `burst_len` = 4, `gap_len` = 3:**
  - `oe` pattern is 1111000, repeating.
  - `frame_done` pulses on the 4th pair of each burst.
  - PRBS bits continue across the gap.
  - With `gap_len` = 0, `oe` stays high and `frame_done` pulses every 4 cycles.
- **Edge cases:** `burst_len` = 0 behaves as 1. `enable` dropped during GAP → IDLE the next cycle, with no `frame_done`.
